// File: rtl/tick_frame_source_if.sv
// Byte-feed input and Q16.16 tick output bundle for tick_frame_source.
// master: the frame source itself. slave: the feed/consumer environment.
interface tick_frame_source_if;
    logic        byte_valid;
    logic        byte_ready;
    logic [7:0]  byte_data;
    logic        tick_valid;
    logic        tick_ready;
    logic [31:0] tick_data;
    logic        crc_err;
    logic        drop;

    modport master (
        input  byte_valid, byte_data, tick_ready,
        output byte_ready, tick_valid, tick_data, crc_err, drop
    );

    modport slave (
        output byte_valid, byte_data, tick_ready,
        input  byte_ready, tick_valid, tick_data, crc_err, drop
    );
endinterface

// File: rtl/tick_frame_source.sv
// Parses sync/4-byte/XOR frames from a byte feed and queues Q16.16 ticks for a valid/ready output.
// Optional TICK_STATS_EN adds saturating good/crc/drop frame counters.
module tick_frame_source #(
    parameter int          DEPTH     = 4,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tick_frame_source_if.master  bus
`ifdef TICK_STATS_EN
    ,
    output logic [15:0]          stat_good,
    output logic [15:0]          stat_crc,
    output logic [15:0]          stat_drop
`endif
);

    localparam int           PW      = $clog2(DEPTH);
    localparam logic [PW:0]  PTR_ONE = {{PW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_t;

    state_t        state_q;
    logic [1:0]    cnt_q;
    logic [31:0]   asm_q;
    logic [7:0]    csum_q;

    logic [31:0]   mem [DEPTH];
    logic [PW:0]   wr_ptr_q, wr_ptr_d;
    logic [PW:0]   rd_ptr_q, rd_ptr_d;

    logic          ready_q;
    logic          tick_valid_q, tick_valid_d;
    logic [31:0]   tick_data_q, tick_data_d;
    logic          crc_err_q;
    logic          drop_q;

    logic          check_byte;
    logic          commit;
    logic          bad_crc;
    logic          pop;
    logic          full_q;
    logic          full_after_pop;
    logic          push;

    always_comb begin
        check_byte     = bus.byte_valid && (state_q == CHECK);
        commit         = check_byte && (bus.byte_data == csum_q);
        bad_crc        = check_byte && (bus.byte_data != csum_q);
        pop            = tick_valid_q && bus.tick_ready;
        full_q         = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                         (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
        // A pop in the same cycle frees the slot the commit needs.
        full_after_pop = full_q && !pop;
        push           = commit && !full_after_pop;

        rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;

        tick_valid_d = (wr_ptr_d != rd_ptr_d);
        tick_data_d  = tick_data_q;
        // Head slot being written this very cycle is not in mem yet; bypass it.
        if (tick_valid_d) begin
            if (push && (rd_ptr_d == wr_ptr_q)) begin
                tick_data_d = asm_q;
            end else begin
                tick_data_d = mem[rd_ptr_d[PW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[PW-1:0]] <= asm_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            cnt_q        <= 2'd0;
            asm_q        <= 32'd0;
            csum_q       <= 8'd0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ready_q      <= 1'b0;
            tick_valid_q <= 1'b0;
            tick_data_q  <= 32'd0;
            crc_err_q    <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            ready_q      <= 1'b1;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            tick_valid_q <= tick_valid_d;
            tick_data_q  <= tick_data_d;
            crc_err_q    <= bad_crc;
            drop_q       <= commit && full_after_pop;

            case (state_q)
                HUNT: begin
                    if (bus.byte_valid && (bus.byte_data == SYNC_BYTE)) begin
                        state_q <= PAYLOAD;
                        cnt_q   <= 2'd0;
                        csum_q  <= 8'd0;
                    end
                end
                PAYLOAD: begin
                    if (bus.byte_valid) begin
                        asm_q  <= {asm_q[23:0], bus.byte_data};
                        csum_q <= csum_q ^ bus.byte_data;
                        cnt_q  <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            state_q <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (bus.byte_valid) begin
                        state_q <= HUNT;
                    end
                end
                default: state_q <= HUNT;
            endcase
        end
    end

    assign bus.byte_ready = ready_q;
    assign bus.tick_valid = tick_valid_q;
    assign bus.tick_data  = tick_data_q;
    assign bus.crc_err    = crc_err_q;
    assign bus.drop       = drop_q;

`ifdef TICK_STATS_EN
    logic [15:0] stat_good_q, stat_crc_q, stat_drop_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_good_q <= 16'd0;
            stat_crc_q  <= 16'd0;
            stat_drop_q <= 16'd0;
        end else begin
            if (push && (stat_good_q != 16'hFFFF)) begin
                stat_good_q <= stat_good_q + 16'd1;
            end
            if (bad_crc && (stat_crc_q != 16'hFFFF)) begin
                stat_crc_q <= stat_crc_q + 16'd1;
            end
            if (commit && full_after_pop && (stat_drop_q != 16'hFFFF)) begin
                stat_drop_q <= stat_drop_q + 16'd1;
            end
        end
    end

    assign stat_good = stat_good_q;
    assign stat_crc  = stat_crc_q;
    assign stat_drop = stat_drop_q;
`endif

endmodule

// File: tb/tb_tick_frame_source.sv
// Directed bench for tick_frame_source: frame-level reference model plus literal expectations.
module tb_tick_frame_source;
    localparam int          DEPTH = 4;
    localparam logic [7:0]  SYNC  = 8'hA5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tick_frame_source_if bus();

`ifdef TICK_STATS_EN
    logic [15:0] stat_good, stat_crc, stat_drop;
`endif

    tick_frame_source #(.DEPTH(DEPTH), .SYNC_BYTE(SYNC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef TICK_STATS_EN
        ,
        .stat_good (stat_good),
        .stat_crc  (stat_crc),
        .stat_drop (stat_drop)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: collect bytes from a sync into a 6-byte frame, judge it whole.
    logic [7:0]  fbuf[$];
    logic [31:0] mq[$];
    logic [31:0] got[$];
    bit          exp_crc = 0, exp_drop = 0, ready_exp = 0;
    bit          popped;
    logic [31:0] word;
    int          mgood = 0, mcrc = 0, mdrop = 0;
    int          n_crc = 0, n_drop = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fbuf.delete();
            mq.delete();
            exp_crc = 0; exp_drop = 0; ready_exp = 0;
            mgood = 0; mcrc = 0; mdrop = 0;
        end else begin
            exp_crc = 0; exp_drop = 0; ready_exp = 1;
            popped = (mq.size() > 0) && bus.tick_ready;
            if (popped) void'(mq.pop_front());
            if (bus.byte_valid) begin
                if (fbuf.size() != 0 || bus.byte_data == SYNC) fbuf.push_back(bus.byte_data);
                if (fbuf.size() == 6) begin
                    word = {fbuf[1], fbuf[2], fbuf[3], fbuf[4]};
                    if ((fbuf[1] ^ fbuf[2] ^ fbuf[3] ^ fbuf[4]) != fbuf[5]) begin
                        exp_crc = 1; mcrc++;
                    end else if (mq.size() < DEPTH) begin
                        mq.push_back(word); mgood++;
                    end else begin
                        exp_drop = 1; mdrop++;
                    end
                    fbuf.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_byte_ready", {31'd0, bus.byte_ready}, 32'd0);
            chk("rst_tick_valid", {31'd0, bus.tick_valid}, 32'd0);
            chk("rst_tick_data",  bus.tick_data, 32'd0);
            chk("rst_crc_err",    {31'd0, bus.crc_err}, 32'd0);
            chk("rst_drop",       {31'd0, bus.drop}, 32'd0);
        end else begin
            chk("byte_ready", {31'd0, bus.byte_ready}, {31'd0, ready_exp});
            chk("tick_valid", {31'd0, bus.tick_valid}, {31'd0, mq.size() != 0});
            if (mq.size() != 0) chk("tick_data", bus.tick_data, mq[0]);
            chk("crc_err", {31'd0, bus.crc_err}, {31'd0, exp_crc});
            chk("drop",    {31'd0, bus.drop},    {31'd0, exp_drop});
            if (bus.crc_err) begin n_crc++;  $display("%0t crc_err pulse", $time); end
            if (bus.drop)    begin n_drop++; $display("%0t drop pulse", $time); end
            if (bus.tick_valid && bus.tick_ready) begin
                got.push_back(bus.tick_data);
                $display("%0t tick out 0x%08h", $time, bus.tick_data);
            end
        end
`ifdef TICK_STATS_EN
        chk("stat_good", {16'd0, stat_good}, mgood);
        chk("stat_crc",  {16'd0, stat_crc},  mcrc);
        chk("stat_drop", {16'd0, stat_drop}, mdrop);
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        step();
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] w);
        send_byte(SYNC);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
        send_byte(w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0]);
    endtask

    int crc0, drop0;

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'd0;
        bus.tick_ready = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(3);

        // Basic frame: 1.5
        got.delete(); crc0 = n_crc;
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h80); send_byte(8'h00); send_byte(8'h81);
        idle(3);
        chk("t1_count", got.size(), 1);
        chk("t1_tick",  got[0], 32'h00018000);
        chk("t1_crc",   n_crc - crc0, 0);

        // Leading garbage ignored: -1.0
        got.delete();
        send_byte(8'h12); send_byte(8'h34);
        send_byte(8'hA5); send_byte(8'hFF); send_byte(8'hFF);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        idle(3);
        chk("t2_count", got.size(), 1);
        chk("t2_tick",  got[0], 32'hFFFF0000);

        // Bad checksum, then a good frame
        got.delete(); crc0 = n_crc;
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h80); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
        idle(3);
        chk("t3_crc_pulses", n_crc - crc0, 1);
        chk("t3_count", got.size(), 1);
        chk("t3_tick",  got[0], 32'h00020000);

        // Overflow: five frames with no drain
        got.delete(); drop0 = n_drop;
        bus.tick_ready = 1'b0;
        for (int k = 1; k <= 5; k++) send_frame(32'(k) << 16);
        idle(2);
        chk("t4_drops",  n_drop - drop0, 1);
        chk("t4_queued", mq.size(), 4);
        chk("t4_none_out", got.size(), 0);
        bus.tick_ready = 1'b1;
        idle(6);
        chk("t4_count", got.size(), 4);
        for (int i = 0; i < 4; i++) chk("t4_order", got[i], 32'(i + 1) << 16);

        // Full FIFO popped on the commit cycle: no drop
        got.delete(); drop0 = n_drop;
        bus.tick_ready = 1'b0;
        for (int k = 1; k <= 4; k++) send_frame(32'(k) << 16);
        send_byte(SYNC); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'h00); send_byte(8'h00);
        bus.tick_ready = 1'b1;
        send_byte(8'h05);
        idle(7);
        chk("t5_drops", n_drop - drop0, 0);
        chk("t5_count", got.size(), 5);
        for (int i = 0; i < 5; i++) chk("t5_order", got[i], 32'(i + 1) << 16);

        // Reset with a queued tick and a partial frame
        bus.tick_ready = 1'b0;
        send_frame(32'h00070000);
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(2);
        got.delete();
        bus.tick_ready = 1'b1;
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h03);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h03);
        idle(3);
        chk("t6_count", got.size(), 1);
        chk("t6_tick",  got[0], 32'h00030000);
`ifdef TICK_STATS_EN
        chk("t6_stat_good", {16'd0, stat_good}, 1);
        chk("t6_stat_crc",  {16'd0, stat_crc},  0);
        chk("t6_stat_drop", {16'd0, stat_drop}, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
